// File: rtl/ib_mul_seq_8x8.sv
// Valid/ready sequencer for the start/done shift-add multiplier: one start per operand pair, watchdog on done.
// Latency accept->o_valid is 3+n cycles (n = A's MSB position + 1); results hold in OUT until i_ready.
module ib_mul_seq_8x8 #(
  parameter int TIMEOUT = 12
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic        o_mul_start,
  output logic [7:0]  o_mul_a,
  output logic [7:0]  o_mul_b,
  input  logic [15:0] i_mul_c,
  input  logic        i_mul_done,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_c,
  output logic        o_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]     r_state;
  logic [WDW-1:0] r_wd;
  logic [7:0]     r_a;
  logic [7:0]     r_b;
  logic [15:0]    r_c;
  logic           r_err;
  logic           w_ready;
  logic           w_accept;

  assign w_ready  = (r_state == S_IDLE) | ((r_state == S_OUT) & i_ready);
  assign w_accept = i_valid & w_ready;

  assign o_ready     = w_ready;
  assign o_mul_start = (r_state == S_START);
  assign o_valid     = (r_state == S_OUT);
  assign o_mul_a     = r_a;
  assign o_mul_b     = r_b;
  assign o_c         = r_c;
  assign o_err       = r_err;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
      r_wd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= i_a;
        r_b <= i_b;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_START;
        end
        S_START: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // done wins over a timeout landing in the same cycle
          if (i_mul_done) begin
            r_c     <= i_mul_c;
            r_err   <= 1'b0;
            r_state <= S_OUT;
          end else begin
            r_wd <= r_wd + 1'b1;
            if (r_wd == WD_LAST) begin
              r_c     <= '0;
              r_err   <= 1'b1;
              r_state <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (i_ready) r_state <= w_accept ? S_START : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ib_mul_seq_8x8.sv
// Directed bench for ib_mul_seq_8x8 with a behavioural start/done multiplier stand-in.
module tb_ib_mul_seq_8x8;

  localparam int TIMEOUT = 12;

  logic        clk;
  logic        nrst;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_a;
  logic [7:0]  i_b;
  logic        o_mul_start;
  logic [7:0]  o_mul_a;
  logic [7:0]  o_mul_b;
  logic [15:0] mul_c;
  logic        mul_done;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_c;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  ib_mul_seq_8x8 #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .o_mul_start(o_mul_start), .o_mul_a(o_mul_a),
    .o_mul_b(o_mul_b), .i_mul_c(mul_c), .i_mul_done(mul_done),
    .o_valid(o_valid), .i_ready(i_ready), .o_c(o_c), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stand-in: done low during start, high again n cycles later
  logic [3:0] m_cnt;
  logic       m_hang;

  function automatic logic [3:0] msb_n(input logic [7:0] a);
    for (int i = 7; i >= 0; i--) if (a[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  always @(posedge clk) begin
    if (o_mul_start) begin
      m_cnt <= msb_n(o_mul_a);
      mul_c <= o_mul_a * o_mul_b;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1'b1;
    end
  end

  assign mul_done = (m_cnt == 0) & !o_mul_start & !m_hang;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called in the START cycle; lat counts cycles since the accept cycle
  task automatic wait_valid(output int lat, output int extra);
    lat = 1;
    extra = 0;
    while (!o_valid && lat < 40) begin
      step;
      lat++;
      if (o_mul_start) extra++;
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_mul_start, o_mul_a, o_mul_b, o_c, o_err} !== 35'd0) begin
      $display("FAIL reset_vals got %h want 0", {o_valid, o_mul_start, o_mul_a, o_mul_b, o_c, o_err});
      errors++;
    end
    step;
    step;
    nrst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step;
      checks++;
      if ({o_ready, o_valid, o_mul_start, o_c, o_err} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0}) begin
        $display("FAIL idle_cycle%0d got %h want %h", i, {o_ready, o_valid, o_mul_start, o_c, o_err},
                 {1'b1, 1'b0, 1'b0, 16'h0, 1'b0});
        errors++;
      end
    end
  endtask

  task automatic test_basic;
    int lat, extra;
    i_ready = 1'b1;
    i_valid = 1'b1; i_a = 8'h0F; i_b = 8'h11;
    checks++;
    if (o_ready !== 1'b1) begin $display("FAIL basic_ready got %b want 1", o_ready); errors++; end
    step;
    i_valid = 1'b0;
    checks++;
    if (o_mul_start !== 1'b1) begin $display("FAIL basic_start got %b want 1", o_mul_start); errors++; end
    wait_valid(lat, extra);
    checks++;
    if (lat !== 7) begin $display("FAIL basic_lat got %0d want 7", lat); errors++; end
    checks++;
    if (extra !== 0) begin $display("FAIL basic_extra_start got %0d want 0", extra); errors++; end
    checks++;
    if ({o_c, o_err} !== {16'h00FF, 1'b0}) begin
      $display("FAIL basic_result got %h/%b want 00ff/0", o_c, o_err); errors++;
    end
    checks++;
    if ({o_mul_a, o_mul_b} !== 16'h0F11) begin
      $display("FAIL basic_operands got %h want 0f11", {o_mul_a, o_mul_b}); errors++;
    end
    step;
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      $display("FAIL basic_idle got %b want 01", {o_valid, o_ready}); errors++;
    end
  endtask

  task automatic test_extremes;
    int lat, extra;
    i_valid = 1'b1; i_a = 8'hFF; i_b = 8'hFF;
    step;
    i_valid = 1'b0;
    wait_valid(lat, extra);
    checks++;
    if (lat !== 11) begin $display("FAIL ff_lat got %0d want 11", lat); errors++; end
    checks++;
    if ({o_c, o_err} !== {16'hFE01, 1'b0}) begin
      $display("FAIL ff_result got %h/%b want fe01/0", o_c, o_err); errors++;
    end
    step;
    i_valid = 1'b1; i_a = 8'h00; i_b = 8'hAB;
    step;
    i_valid = 1'b0;
    checks++;
    if (o_mul_start !== 1'b1) begin $display("FAIL zero_start got %b want 1", o_mul_start); errors++; end
    wait_valid(lat, extra);
    checks++;
    if (lat !== 3) begin $display("FAIL zero_lat got %0d want 3", lat); errors++; end
    checks++;
    if ({o_c, o_err} !== {16'h0000, 1'b0}) begin
      $display("FAIL zero_result got %h/%b want 0000/0", o_c, o_err); errors++;
    end
    step;
  endtask

  task automatic test_back_to_back;
    int lat, extra, bad;
    i_ready = 1'b0;
    i_valid = 1'b1; i_a = 8'h03; i_b = 8'h05;
    step;
    i_a = 8'h02; i_b = 8'h07;
    wait_valid(lat, extra);
    checks++;
    if (lat !== 5) begin $display("FAIL bp_lat got %0d want 5", lat); errors++; end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({o_valid, o_ready, o_mul_start, o_c, o_mul_a} !== {1'b1, 1'b0, 1'b0, 16'h000F, 8'h03}) bad++;
      step;
    end
    checks++;
    if (bad !== 0) begin $display("FAIL bp_hold got %0d bad cycles want 0", bad); errors++; end
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin $display("FAIL bp_ready got %b want 1", o_ready); errors++; end
    step;
    i_valid = 1'b0;
    checks++;
    if ({o_mul_start, o_valid, o_mul_a, o_mul_b} !== {1'b1, 1'b0, 8'h02, 8'h07}) begin
      $display("FAIL bp_restart got %h want %h", {o_mul_start, o_valid, o_mul_a, o_mul_b},
               {1'b1, 1'b0, 8'h02, 8'h07});
      errors++;
    end
    wait_valid(lat, extra);
    checks++;
    if ({o_c, o_err} !== {16'h000E, 1'b0} || lat !== 5) begin
      $display("FAIL bp_second got %h/%b lat %0d want 000e/0 lat 5", o_c, o_err, lat); errors++;
    end
    step;
  endtask

  task automatic test_timeout;
    int lat, extra;
    m_hang = 1'b1;
    i_valid = 1'b1; i_a = 8'h05; i_b = 8'h05;
    step;
    i_valid = 1'b0;
    wait_valid(lat, extra);
    checks++;
    if (lat !== TIMEOUT + 2) begin $display("FAIL to_lat got %0d want %0d", lat, TIMEOUT + 2); errors++; end
    checks++;
    if ({o_c, o_err} !== {16'h0000, 1'b1}) begin
      $display("FAIL to_result got %h/%b want 0000/1", o_c, o_err); errors++;
    end
    step;
    m_hang = 1'b0;
    i_valid = 1'b1; i_a = 8'h09; i_b = 8'h03;
    step;
    i_valid = 1'b0;
    wait_valid(lat, extra);
    checks++;
    if ({o_c, o_err} !== {16'h001B, 1'b0} || lat !== 7) begin
      $display("FAIL to_recover got %h/%b lat %0d want 001b/0 lat 7", o_c, o_err, lat); errors++;
    end
    step;
  endtask

  task automatic test_reset_mid;
    int lat, extra, bad;
    i_valid = 1'b1; i_a = 8'h80; i_b = 8'h02;
    step;
    i_valid = 1'b0;
    step;
    step;
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_mul_start, o_mul_a, o_mul_b, o_c, o_err} !== 35'd0) begin
      $display("FAIL midrst_vals got %h want 0", {o_valid, o_mul_start, o_mul_a, o_mul_b, o_c, o_err});
      errors++;
    end
    step;
    step;
    #3;
    nrst = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step;
      if (o_valid || o_mul_start) bad++;
    end
    checks++;
    if (bad !== 0) begin $display("FAIL midrst_quiet got %0d bad cycles want 0", bad); errors++; end
    i_valid = 1'b1; i_a = 8'h01; i_b = 8'h07;
    step;
    i_valid = 1'b0;
    wait_valid(lat, extra);
    checks++;
    if ({o_c, o_err} !== {16'h0007, 1'b0} || lat !== 4) begin
      $display("FAIL midrst_next got %h/%b lat %0d want 0007/0 lat 4", o_c, o_err, lat); errors++;
    end
    step;
  endtask

  initial begin
    nrst = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_ready = 1'b1;
    m_hang = 1'b0; m_cnt = '0; mul_c = '0;
    test_reset;
    test_basic;
    test_extremes;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
